// File: rtl/mips_regfile_2r1w.sv
// Register file for the MIPS core: two combinational read ports, one write port,
// optional write-to-read bypass and a per-register pending scoreboard for RAW detection.
module mips_regfile_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    // No handshake: one write and one scoreboard set are accepted every cycle.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;

    logic wr_en, set_en, cnt_inc, cnt_dec;

    assign wr_en  = we     && !((ZERO_REG != 0) && (waddr   == '0));
    assign set_en = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));

    // A set to the register being written wins: a new producer has just issued.
    always_comb begin
        pend_d = pend_q;
        if (wr_en) begin
            pend_d[waddr] = 1'b0;
        end
        if (set_en) begin
            pend_d[sb_addr] = 1'b1;
        end
    end

    assign cnt_inc = set_en && !pend_q[sb_addr];
    assign cnt_dec = wr_en && pend_q[waddr] && !(set_en && (sb_addr == waddr));

    always_comb begin
        pend_cnt_d = pend_cnt_q + (ADDR_W + 1)'(cnt_inc) - (ADDR_W + 1)'(cnt_dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[waddr] <= wdata;
            end
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

    always_comb begin
        rdata_a = mem_q[raddr_a];
        busy_a  = pend_q[raddr_a];
        if ((BYPASS != 0) && we && (waddr == raddr_a)) begin
            rdata_a = wdata;
            busy_a  = 1'b0;
        end
        if ((ZERO_REG != 0) && (raddr_a == '0)) begin
            rdata_a = '0;
            busy_a  = 1'b0;
        end
    end

    always_comb begin
        rdata_b = mem_q[raddr_b];
        busy_b  = pend_q[raddr_b];
        if ((BYPASS != 0) && we && (waddr == raddr_b)) begin
            rdata_b = wdata;
            busy_b  = 1'b0;
        end
        if ((ZERO_REG != 0) && (raddr_b == '0)) begin
            rdata_b = '0;
            busy_b  = 1'b0;
        end
    end

endmodule
